alu_unit: RTL

Sequential 8-bit arithmetic/logic unit for the bus computer. Sits directly downstream of the A and B registers: it consumes their outputs, computes on a `start` strobe, and holds the result and flags in internal registers. The result is driven back onto the data bus when `OE` is asserted. Single-cycle operations complete in one edge; multiply runs as an 8-iteration shift-add with a busy/done handshake.

---
 rtl/alu_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_unit.sv
// alu_unit: sequential 8-bit ALU for the bus computer.
// Single-cycle ops complete on the start edge; MUL runs an 8-step shift-add
// with busy/done handshake. Result and flags are held in registers, and the
// result is driven onto ALU_out only while OE is high.
module alu_unit (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic [7:0] A_in,
    input  logic [7:0] B_in,
    input  logic [2:0] op,
    input  logic       start,
    input  logic       OE,
    output logic [7:0] ALU_out,
    output logic [7:0] MUL_hi,
    output logic       C,
    output logic       Z,
    output logic       N,
    output logic       V,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    state_t      state_q, state_d;
    logic [7:0]  res_q,   res_d;
    logic [7:0]  hi_q,    hi_d;
    logic        c_q,     c_d;
    logic        z_q,     z_d;
    logic        n_q,     n_d;
    logic        v_q,     v_d;
    logic        done_q,  done_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q,   acc_d;
    logic [2:0]  cnt_q,   cnt_d;

    op_t         op_sel;
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [7:0]  alu_res;
    logic        alu_c;
    logic        alu_v;
    logic [15:0] addend;
    logic [15:0] acc_next;

    assign op_sel = op_t'(op);

    // Single-cycle datapath: result, carry and overflow for the non-MUL ops
    always_comb begin
        sum9    = {1'b0, A_in} + {1'b0, B_in};
        diff9   = {1'b0, A_in} + {1'b0, ~B_in} + 9'd1;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op_sel)
            OP_ADD: begin
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
                alu_v   = (A_in[7] == B_in[7]) && (sum9[7] != A_in[7]);
            end
            OP_SUB: begin
                // carry out of A + ~B + 1 is the "no borrow" (A >= B) flag
                alu_res = diff9[7:0];
                alu_c   = diff9[8];
                alu_v   = (A_in[7] != B_in[7]) && (diff9[7] != A_in[7]);
            end
            OP_AND: alu_res = A_in & B_in;
            OP_OR:  alu_res = A_in | B_in;
            OP_XOR: alu_res = A_in ^ B_in;
            OP_SHL: begin
                alu_res = {A_in[6:0], 1'b0};
                alu_c   = A_in[7];
            end
            OP_SHR: begin
                alu_res = {1'b0, A_in[7:1]};
                alu_c   = A_in[0];
            end
            default: begin
                alu_res = '0;
            end
        endcase
    end

    // Shift-add step: partial product for the current multiplier bit
    always_comb begin
        addend   = mplier_q[0] ? ({8'h00, mcand_q} << cnt_q) : '0;
        acc_next = acc_q + addend;
    end

    // Next-state logic: operation acceptance, multiply iteration, result write
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        hi_d     = hi_q;
        c_d      = c_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_sel == OP_MUL) begin
                        mcand_d  = A_in;
                        mplier_d = B_in;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        res_d  = alu_res;
                        hi_d   = '0;
                        c_d    = alu_c;
                        z_d    = (alu_res == 8'h00);
                        n_d    = alu_res[7];
                        v_d    = alu_v;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_next;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    res_d   = acc_next[7:0];
                    hi_d    = acc_next[15:8];
                    c_d     = (acc_next[15:8] != 8'h00);
                    z_d     = (acc_next == 16'h0000);
                    n_d     = acc_next[7];
                    v_d     = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            hi_q     <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ALU_out = OE ? res_q : '0;
    assign MUL_hi  = hi_q;
    assign C       = c_q;
    assign Z       = z_q;
    assign N       = n_q;
    assign V       = v_q;
    assign busy    = (state_q == S_MUL);
    assign done    = done_q;

endmodule
